region_dispatcher: RTL and testbench

Transmit side of the load balancer. Takes one request descriptor at a time from the load balancer's metadata queue and picks the region with the most effective free capacity. It forwards the descriptor to that region over an AXI4-Stream master with a destination index. It also tracks outstanding requests per region and exports dispatch/stall counters for the control registers.

---
 rtl/lb_pkg.sv | 14 +
 rtl/region_argmax.sv | 31 +++
 rtl/region_dispatcher.sv | 131 +++++++++++++
 tb/tb_region_dispatcher.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// Shared load-balancer definitions: dispatcher FSM states and default field widths.
package lb_pkg;

  localparam int N_REGIONS_MAX          = 16;
  localparam int DEFAULT_STAT_WIDTH     = 16;
  localparam int DEFAULT_INFLIGHT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    SEND   = 2'd2
  } lb_state_e;

endpackage

// File: rtl/region_argmax.sv
// Combinational argmax over a packed vector of per-region capacities.
// Ties resolve to the lowest index; a region is eligible only with a non-zero value.
module region_argmax
  import lb_pkg::*;
#(
  parameter int  N  = 4,
  parameter int  W  = DEFAULT_STAT_WIDTH,
  localparam int IW = $clog2(N)
) (
  input  logic [N*W-1:0] eff,
  output logic [IW-1:0]  idx,
  output logic           any_eligible
);

  logic [W-1:0] best;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    best = '0;
    idx  = '0;
    // Strict '>' keeps the earliest index on equal values.
    for (int i = 0; i < N; i++) begin
      if (eff[i*W +: W] > best) begin
        best = eff[i*W +: W];
        idx  = IW'(i);
      end
    end
    any_eligible = (best != '0);
  end

endmodule

// File: rtl/region_dispatcher.sv
// Transmit side of the load balancer: forwards each metadata descriptor to the region
// with the most effective free capacity and tracks outstanding requests per region.
module region_dispatcher
  import lb_pkg::*;
#(
  parameter int  HTTP_DATA_WIDTH = 8,
  parameter int  N_REGIONS       = 4,
  parameter int  STAT_WIDTH      = DEFAULT_STAT_WIDTH,
  parameter int  INFLIGHT_WIDTH  = DEFAULT_INFLIGHT_WIDTH,
  localparam int DEST_WIDTH      = $clog2(N_REGIONS)
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            meta_snk_tvalid,
  output logic                            meta_snk_tready,
  input  logic [HTTP_DATA_WIDTH-1:0]      meta_snk_tdata,
  output logic                            req_src_tvalid,
  input  logic                            req_src_tready,
  output logic [HTTP_DATA_WIDTH-1:0]      req_src_tdata,
  output logic [DEST_WIDTH-1:0]           req_dest,
  input  logic [N_REGIONS*STAT_WIDTH-1:0] region_stats_in,
  input  logic [N_REGIONS-1:0]            region_done,
  output logic [31:0]                     dispatch_cnt,
  output logic [31:0]                     stall_cnt,
  output logic                            done_err
);

  localparam int CW = (STAT_WIDTH > INFLIGHT_WIDTH) ? STAT_WIDTH : INFLIGHT_WIDTH;
  localparam logic [INFLIGHT_WIDTH-1:0] INFLIGHT_MAX = '1;

  lb_state_e                 state;
  logic [INFLIGHT_WIDTH-1:0] inflight [N_REGIONS];
  logic [N_REGIONS*STAT_WIDTH-1:0] eff;
  logic [DEST_WIDTH-1:0]     sel_idx;
  logic                      sel_valid;
  logic                      send_fire;
  logic [N_REGIONS-1:0]      inc, dec;

  // Capacity compared in a common width so a wide inflight counter never truncates.
  always_comb begin
    eff = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      logic [CW-1:0] s_ext, f_ext;
      s_ext = CW'(region_stats_in[i*STAT_WIDTH +: STAT_WIDTH]);
      f_ext = CW'(inflight[i]);
      if (inflight[i] != INFLIGHT_MAX && s_ext > f_ext)
        eff[i*STAT_WIDTH +: STAT_WIDTH] = STAT_WIDTH'(s_ext - f_ext);
    end
  end

  region_argmax #(
    .N (N_REGIONS),
    .W (STAT_WIDTH)
  ) u_argmax (
    .eff          (eff),
    .idx          (sel_idx),
    .any_eligible (sel_valid)
  );

  assign send_fire = (state == SEND) && req_src_tready;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      inc[i] = send_fire && (req_dest == DEST_WIDTH'(i));
      dec[i] = region_done[i] && (inflight[i] != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state           <= IDLE;
      meta_snk_tready <= 1'b0;
      req_src_tvalid  <= 1'b0;
      req_src_tdata   <= '0;
      req_dest        <= '0;
      dispatch_cnt    <= '0;
      stall_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (meta_snk_tvalid && meta_snk_tready) begin
            req_src_tdata   <= meta_snk_tdata;
            meta_snk_tready <= 1'b0;
            state           <= SELECT;
          end else begin
            meta_snk_tready <= 1'b1;
          end
        end
        SELECT: begin
          if (sel_valid) begin
            req_dest       <= sel_idx;
            req_src_tvalid <= 1'b1;
            state          <= SEND;
          end else begin
            stall_cnt <= stall_cnt + 32'd1;
          end
        end
        SEND: begin
          if (req_src_tready) begin
            req_src_tvalid  <= 1'b0;
            meta_snk_tready <= 1'b1;
            dispatch_cnt    <= dispatch_cnt + 32'd1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the inflight array is a handful of counters, not a RAM, so it is cleared on reset like any register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < N_REGIONS; i++) inflight[i] <= '0;
      done_err <= 1'b0;
    end else begin
      for (int i = 0; i < N_REGIONS; i++) begin
        if (region_done[i] && inflight[i] == '0) done_err <= 1'b1;
        case ({inc[i], dec[i]})
          2'b10:   inflight[i] <= inflight[i] + INFLIGHT_WIDTH'(1);
          2'b01:   inflight[i] <= inflight[i] - INFLIGHT_WIDTH'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_region_dispatcher.sv
// Self-checking bench for region_dispatcher against a transaction-level capacity model.
module tb_region_dispatcher;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int SW = 16;
  localparam int IW = 8;
  localparam int DEST_W = 2;

  logic              aclk = 1'b0;
  logic              areset;
  logic              meta_snk_tvalid;
  logic              meta_snk_tready;
  logic [DW-1:0]     meta_snk_tdata;
  logic              req_src_tvalid;
  logic              req_src_tready;
  logic [DW-1:0]     req_src_tdata;
  logic [DEST_W-1:0] req_dest;
  logic [NR*SW-1:0]  region_stats_in;
  logic [NR-1:0]     region_done;
  logic [31:0]       dispatch_cnt;
  logic [31:0]       stall_cnt;
  logic              done_err;

  always #5 aclk = ~aclk;

  region_dispatcher #(
    .HTTP_DATA_WIDTH (DW),
    .N_REGIONS       (NR),
    .STAT_WIDTH      (SW),
    .INFLIGHT_WIDTH  (IW)
  ) dut (
    .aclk            (aclk),
    .areset          (areset),
    .meta_snk_tvalid (meta_snk_tvalid),
    .meta_snk_tready (meta_snk_tready),
    .meta_snk_tdata  (meta_snk_tdata),
    .req_src_tvalid  (req_src_tvalid),
    .req_src_tready  (req_src_tready),
    .req_src_tdata   (req_src_tdata),
    .req_dest        (req_dest),
    .region_stats_in (region_stats_in),
    .region_done     (region_done),
    .dispatch_cnt    (dispatch_cnt),
    .stall_cnt       (stall_cnt),
    .done_err        (done_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: capacity stats, outstanding count per region, counters.
  int stats      [NR];
  int m_inflight [NR];
  int m_disp  = 0;
  int m_stall = 0;
  bit m_err   = 1'b0;
  int exp_dest = 0;
  bit rand_done_en = 1'b0;

  task automatic set_stats();
    for (int i = 0; i < NR; i++) region_stats_in[i*SW +: SW] = stats[i][SW-1:0];
  endtask

  // Region with the largest positive spare capacity, lowest index on ties; -1 if none.
  function automatic int model_dest();
    int best = 0;
    int bi   = -1;
    for (int i = 0; i < NR; i++) begin
      int e;
      e = stats[i] - m_inflight[i];
      if (e < 0 || m_inflight[i] == (1 << IW) - 1) e = 0;
      if (e > best) begin
        best = e;
        bi   = i;
      end
    end
    return bi;
  endfunction

  // One clock: the model absorbs the same edge the DUT sees, then outputs are sampled 1ns later.
  task automatic tick();
    bit            fire, rst;
    logic [NR-1:0] d;
    if (rand_done_en && $urandom_range(0, 3) == 0) region_done = region_done | NR'($urandom);
    fire = req_src_tvalid && req_src_tready;
    rst  = areset;
    d    = region_done;
    @(posedge aclk);
    if (rst) begin
      for (int i = 0; i < NR; i++) m_inflight[i] = 0;
      m_disp = 0; m_stall = 0; m_err = 1'b0;
    end else begin
      for (int i = 0; i < NR; i++)
        if (d[i]) begin
          if (m_inflight[i] > 0) m_inflight[i]--;
          else m_err = 1'b1;
        end
      if (fire) begin
        m_inflight[exp_dest]++;
        m_disp++;
      end
    end
    #1;
    region_done = '0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    tick();
  endtask

  task automatic meta_handshake(input logic [DW-1:0] data, input string name);
    bit hs = 1'b0;
    int guard = 0;
    meta_snk_tvalid = 1'b1;
    meta_snk_tdata  = data;
    while (!hs && guard < 20) begin
      hs = meta_snk_tready;
      tick();
      guard++;
    end
    meta_snk_tvalid = 1'b0;
    n_tests++;
    if (hs !== 1'b1) begin
      n_fail++;
      $display("FAIL %s meta_handshake: tready seen=%0b required=1 within 20 cycles", name, hs);
    end
  endtask

  task automatic send_desc(input logic [DW-1:0] data, input int bp, input bit scramble,
                           input logic [NR-1:0] done_on_fire, input string name);
    req_src_tready = 1'b0;
    meta_handshake(data, name);
    exp_dest = model_dest();
    if (exp_dest < 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s no_eligible: model has no eligible region, required one", name);
      return;
    end
    tick();
    n_tests++;
    if (req_src_tvalid !== 1'b1 || req_src_tdata !== data || req_dest !== DEST_W'(exp_dest)) begin
      n_fail++;
      $display("FAIL %s first_send: tvalid=%0b tdata=%h dest=%0d required tvalid=1 tdata=%h dest=%0d",
               name, req_src_tvalid, req_src_tdata, req_dest, data, exp_dest);
    end
    for (int c = 0; c < bp; c++) begin
      if (scramble) begin
        for (int i = 0; i < NR; i++) stats[i] = $urandom_range(0, 40);
        set_stats();
      end
      tick();
      n_tests++;
      if (req_src_tvalid !== 1'b1 || req_src_tdata !== data || req_dest !== DEST_W'(exp_dest) ||
          meta_snk_tready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s hold_c%0d: tvalid=%0b tdata=%h dest=%0d mready=%0b required 1/%h/%0d/0",
                 name, c, req_src_tvalid, req_src_tdata, req_dest, meta_snk_tready, data, exp_dest);
      end
    end
    req_src_tready = 1'b1;
    region_done    = done_on_fire;
    tick();
    req_src_tready = 1'b0;
    n_tests++;
    if (req_src_tvalid !== 1'b0 || meta_snk_tready !== 1'b1 || dispatch_cnt !== 32'(m_disp)) begin
      n_fail++;
      $display("FAIL %s after_fire: tvalid=%0b mready=%0b dispatch_cnt=%0d required 0/1/%0d",
               name, req_src_tvalid, meta_snk_tready, dispatch_cnt, m_disp);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1; meta_snk_tvalid = 1'b0; meta_snk_tdata = '0;
    req_src_tready = 1'b0; region_done = '0;
    for (int i = 0; i < NR; i++) stats[i] = 0;
    set_stats();
    repeat (3) tick();
    n_tests++;
    if (meta_snk_tready !== 1'b0 || req_src_tvalid !== 1'b0 || req_src_tdata !== '0 || req_dest !== '0 ||
        dispatch_cnt !== '0 || stall_cnt !== '0 || done_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: mready=%0b tvalid=%0b tdata=%h dest=%0d disp=%0d stall=%0d err=%0b required all 0",
               meta_snk_tready, req_src_tvalid, req_src_tdata, req_dest, dispatch_cnt, stall_cnt, done_err);
    end
    areset = 1'b0;
    tick();
    n_tests++;
    if (meta_snk_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: mready=%0b required 1", meta_snk_tready);
    end
  endtask

  task automatic test_basic();
    stats[0] = 1; stats[1] = 5; stats[2] = 3; stats[3] = 2;
    set_stats();
    send_desc(8'hAA, 0, 1'b0, '0, "basic");
    n_tests++;
    if (req_dest !== 2'd1 || dispatch_cnt !== 32'd1 || dut.inflight[1] !== 8'd1) begin
      n_fail++;
      $display("FAIL basic_result: dest=%0d disp=%0d inflight1=%0d required 1/1/1",
               req_dest, dispatch_cnt, dut.inflight[1]);
    end
  endtask

  task automatic test_tie_credit();
    logic [DW-1:0] pay [5];
    int            want [5];
    pay[0] = 8'hBB; pay[1] = 8'hCC; pay[2] = 8'hDD; pay[3] = 8'h31; pay[4] = 8'h32;
    want[0] = 0; want[1] = 1; want[2] = 2; want[3] = 3; want[4] = 0;
    do_reset();
    for (int i = 0; i < NR; i++) stats[i] = 2;
    set_stats();
    for (int k = 0; k < 5; k++) begin
      send_desc(pay[k], 0, 1'b0, '0, "tie");
      n_tests++;
      if (req_dest !== DEST_W'(want[k])) begin
        n_fail++;
        $display("FAIL tie_dest%0d: dest=%0d required %0d", k, req_dest, want[k]);
      end
    end
    n_tests++;
    if (dut.inflight[0] !== 8'd2) begin
      n_fail++;
      $display("FAIL tie_credit0: inflight0=%0d required 2 (eff0=0)", dut.inflight[0]);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < NR; i++) stats[i] = 0;
    set_stats();
    meta_handshake(8'hEE, "stall");
    for (int c = 0; c < 4; c++) begin
      tick();
      m_stall++;
      n_tests++;
      if (req_src_tvalid !== 1'b0 || meta_snk_tready !== 1'b0 || stall_cnt !== 32'(m_stall)) begin
        n_fail++;
        $display("FAIL stall_c%0d: tvalid=%0b mready=%0b stall_cnt=%0d required 0/0/%0d",
                 c, req_src_tvalid, meta_snk_tready, stall_cnt, m_stall);
      end
    end
    stats[2] = 1;
    set_stats();
    exp_dest = model_dest();
    tick();
    n_tests++;
    if (req_src_tvalid !== 1'b1 || req_dest !== 2'd2 || req_src_tdata !== 8'hEE || stall_cnt !== 32'(m_stall)) begin
      n_fail++;
      $display("FAIL stall_release: tvalid=%0b dest=%0d tdata=%h stall_cnt=%0d required 1/2/ee/%0d",
               req_src_tvalid, req_dest, req_src_tdata, stall_cnt, m_stall);
    end
    req_src_tready = 1'b1;
    tick();
    req_src_tready = 1'b0;
  endtask

  task automatic test_back_pressure();
    for (int i = 0; i < NR; i++) stats[i] = 20 + i;
    set_stats();
    send_desc(8'h5A, 5, 1'b1, '0, "backpressure");
  endtask

  task automatic test_done();
    do_reset();
    stats[0] = 1; stats[1] = 8; stats[2] = 1; stats[3] = 1;
    set_stats();
    send_desc(8'h11, 0, 1'b0, '0, "done_a");
    send_desc(8'h22, 0, 1'b0, 4'b0010, "done_b");
    n_tests++;
    if (dut.inflight[1] !== 8'd1 || done_err !== 1'b0) begin
      n_fail++;
      $display("FAIL done_net_zero: inflight1=%0d err=%0b required 1/0", dut.inflight[1], done_err);
    end
    region_done = 4'b1000;
    tick();
    n_tests++;
    if (done_err !== 1'b1) begin
      n_fail++;
      $display("FAIL done_err_set: err=%0b required 1", done_err);
    end
    repeat (3) tick();
    n_tests++;
    if (done_err !== 1'b1 || dut.inflight[3] !== 8'd0) begin
      n_fail++;
      $display("FAIL done_err_sticky: err=%0b inflight3=%0d required 1/0", done_err, dut.inflight[3]);
    end
  endtask

  task automatic test_reset_mid_send();
    bit bad = 1'b0;
    for (int i = 0; i < NR; i++) stats[i] = 3;
    set_stats();
    meta_handshake(8'h66, "rst_mid");
    exp_dest = model_dest();
    tick();
    areset = 1'b1;
    tick();
    for (int i = 0; i < NR; i++) if (dut.inflight[i] !== 8'd0) bad = 1'b1;
    n_tests++;
    if (req_src_tvalid !== 1'b0 || dispatch_cnt !== '0 || stall_cnt !== '0 || done_err !== 1'b0 || bad) begin
      n_fail++;
      $display("FAIL rst_mid_clear: tvalid=%0b disp=%0d stall=%0d err=%0b inflight_nonzero=%0b required all 0",
               req_src_tvalid, dispatch_cnt, stall_cnt, done_err, bad);
    end
    areset = 1'b0;
    tick();
    send_desc(8'h77, 1, 1'b0, '0, "rst_after");
    n_tests++;
    if (dispatch_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL rst_after_cnt: dispatch_cnt=%0d required 1", dispatch_cnt);
    end
  endtask

  task automatic test_random();
    bit bad = 1'b0;
    rand_done_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < NR; i++) stats[i] = 16 + $urandom_range(0, 2);
      set_stats();
      send_desc(DW'($urandom), $urandom_range(0, 3), 1'b0, '0, "random");
    end
    rand_done_en = 1'b0;
    tick();
    for (int i = 0; i < NR; i++) if (dut.inflight[i] !== IW'(m_inflight[i])) bad = 1'b1;
    n_tests++;
    if (dispatch_cnt !== 32'(m_disp) || stall_cnt !== 32'(m_stall) || done_err !== m_err || bad) begin
      n_fail++;
      $display("FAIL random_final: disp=%0d stall=%0d err=%0b inflight_diff=%0b required %0d/%0d/%0b/0",
               dispatch_cnt, stall_cnt, done_err, bad, m_disp, m_stall, m_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie_credit();
    test_stall();
    test_back_pressure();
    test_done();
    test_reset_mid_send();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
